// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for pipelined_shifter: upstream operation channel and downstream result channel.
// out_carry exists only when SHIFTER_CARRY_EN is defined.
interface pipelined_shifter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef SHIFTER_CARRY_EN
  logic             out_carry;
`endif

  modport master (
    output in_valid, in_data, in_op, in_amt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
`ifdef SHIFTER_CARRY_EN
    , input out_carry
`endif
  );

  modport slave (
    input  in_valid, in_data, in_op, in_amt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
`ifdef SHIFTER_CARRY_EN
    , output out_carry
`endif
  );
endinterface

// File: rtl/pipelined_shifter.sv
// AMT_W-stage pipelined barrel shifter (SRL/SRA/SLL/ROR) with valid/ready flow control and a tag.
// Define SHIFTER_CARRY_EN to add the pipelined out_carry (last bit shifted out).
module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  pipelined_shifter_if.slave sif
);

  localparam int LAST = AMT_W - 1;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] x,
                                                input logic [1:0] op, input int d);
    logic signed [WIDTH-1:0] sx;
    sx = x;
    case (op)
      OP_SRL:  return x >> d;
      OP_SRA:  return sx >>> d;
      OP_SLL:  return x << d;
      OP_ROR:  return (x >> d) | (x << (WIDTH - d));
      default: return x;
    endcase
  endfunction

`ifdef SHIFTER_CARRY_EN
  // Last bit leaving the word when x is shifted by d; for ROR this is the new MSB, i.e. x[d-1].
  function automatic logic carry_by(input logic [WIDTH-1:0] x,
                                    input logic [1:0] op, input int d);
    case (op)
      OP_SRL:  return x[d-1];
      OP_SRA:  return x[d-1];
      OP_SLL:  return x[WIDTH-d];
      OP_ROR:  return x[d-1];
      default: return 1'b0;
    endcase
  endfunction
`endif

  logic en_s;

  assign en_s         = !(g_stage[LAST].valid_q && !sif.out_ready);
  assign sif.in_ready = en_s;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int DIST = 32'd1 << k;
    localparam int SW   = AMT_W - k;

    logic             src_valid_s;
    logic [WIDTH-1:0] src_data_s;
    logic [1:0]       src_op_s;
    logic [SW-1:0]    src_amt_s;
    logic [TAG_W-1:0] src_tag_s;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [TAG_W-1:0] tag_q;
`ifdef SHIFTER_CARRY_EN
    logic             src_carry_s;
    logic             carry_d;
    logic             carry_q;
`endif

    if (k == 0) begin : g_head
      assign src_valid_s = sif.in_valid;
      assign src_data_s  = sif.in_data;
      assign src_op_s    = sif.in_op;
      assign src_amt_s   = sif.in_amt;
      assign src_tag_s   = sif.in_tag;
`ifdef SHIFTER_CARRY_EN
      assign src_carry_s = 1'b0;
`endif
    end else begin : g_body
      assign src_valid_s = g_stage[k-1].valid_q;
      assign src_data_s  = g_stage[k-1].data_q;
      assign src_op_s    = g_stage[k-1].g_fwd.op_q;
      assign src_amt_s   = g_stage[k-1].g_fwd.amt_q;
      assign src_tag_s   = g_stage[k-1].tag_q;
`ifdef SHIFTER_CARRY_EN
      assign src_carry_s = g_stage[k-1].carry_q;
`endif
    end

    // Shift by 2^k when this stage's amount bit is set, otherwise pass through
    always_comb begin
      data_d = src_data_s;
`ifdef SHIFTER_CARRY_EN
      carry_d = src_carry_s;
`endif
      if (src_amt_s[0]) begin
        data_d = shift_by(src_data_s, src_op_s, DIST);
`ifdef SHIFTER_CARRY_EN
        carry_d = carry_by(src_data_s, src_op_s, DIST);
`endif
      end else begin
        data_d = src_data_s;
`ifdef SHIFTER_CARRY_EN
        carry_d = src_carry_s;
`endif
      end
    end

    // Stage payload register; the whole pipe freezes together while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else if (en_s) begin
        valid_q <= src_valid_s;
        data_q  <= data_d;
        tag_q   <= src_tag_s;
      end
    end

`ifdef SHIFTER_CARRY_EN
    // Carry travels with its data word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        carry_q <= 1'b0;
      end else if (en_s) begin
        carry_q <= carry_d;
      end
    end
`endif

    // The final stage needs neither the op nor any remaining amount bits
    if (k < LAST) begin : g_fwd
      logic [1:0]    op_q;
      logic [SW-2:0] amt_q;

      // Op and not-yet-consumed amount bits for the downstream stages
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          op_q  <= 2'b00;
          amt_q <= '0;
        end else if (en_s) begin
          op_q  <= src_op_s;
          amt_q <= src_amt_s[SW-1:1];
        end
      end
    end
  end

  assign sif.out_valid = g_stage[LAST].valid_q;
  assign sif.out_data  = g_stage[LAST].data_q;
  assign sif.out_tag   = g_stage[LAST].tag_q;
`ifdef SHIFTER_CARRY_EN
  assign sif.out_carry = g_stage[LAST].carry_q;
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (WIDTH=32): directed latency/stream/stall/reset/carry cases
// plus a sweep against a behavioural shift model under random backpressure.
module tb_pipelined_shifter;
  localparam int W  = 32;
  localparam int AW = $clog2(W);
  localparam int TW = 4;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          carry;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   n_checks;
  int   n_fail;
  int   rdy_mode;
  int   cyc;
  int   last_pop_cyc;
  int   prev_pop_cyc;

  pipelined_shifter_if #(.WIDTH(W), .AMT_W(AW), .TAG_W(TW)) sif();

  pipelined_shifter #(.WIDTH(W), .AMT_W(AW), .TAG_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mdl(input logic [W-1:0] x, input logic [1:0] op, input int s);
    logic signed [W-1:0] sx;
    sx = x;
    case (op)
      2'b00:   return x >> s;
      2'b01:   return sx >>> s;
      2'b10:   return x << s;
      2'b11:   return (s == 0) ? x : ((x >> s) | (x << (W - s)));
      default: return '0;
    endcase
  endfunction

  function automatic logic mdl_carry(input logic [W-1:0] x, input logic [1:0] op, input int s);
    logic [W-1:0] r;
    r = mdl(x, op, s);
    if (s == 0) return 1'b0;
    case (op)
      2'b00, 2'b01: return x[s-1];
      2'b10:        return x[W-s];
      default:      return r[W-1];
    endcase
  endfunction

  task automatic send_exp(input logic [W-1:0] d, input logic [1:0] op, input int amt,
                          input logic [TW-1:0] tag, input logic [W-1:0] ed, input logic ec);
    bit acc;
    int n;
    exp_t e;
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    sif.in_op    = op;
    sif.in_amt   = AW'(amt);
    sif.in_tag   = tag;
    n = 0;
    do begin
      @(negedge clk);
      acc = sif.in_ready;
      if (acc) begin
        e.data = ed; e.tag = tag; e.carry = ec;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic send(input logic [W-1:0] d, input logic [1:0] op, input int amt,
                      input logic [TW-1:0] tag);
    send_exp(d, op, amt, tag, mdl(d, op, amt), mdl_carry(d, op, amt));
  endtask

  task automatic idle();
    sif.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       sif.out_ready = 1'b1;
        1:       sif.out_ready = 1'($urandom_range(0, 1));
        default: sif.out_ready = 1'b0;
      endcase
    end
  end

  // Output monitor: a transfer happens at the next rising edge when valid&&ready here
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sif.out_valid && sif.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(sif.out_data), 64'(e.data));
          chk("out_tag", 64'(sif.out_tag), 64'(e.tag));
`ifdef SHIFTER_CARRY_EN
          chk("out_carry", 64'(sif.out_carry), 64'(e.carry));
`endif
          prev_pop_cyc = last_pop_cyc;
          last_pop_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int lat;
    int quiet;
    n_checks = 0;
    n_fail = 0;
    rdy_mode = 0;
    last_pop_cyc = 0;
    prev_pop_cyc = 0;
    rst_n = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data = '0;
    sif.in_op = 2'b00;
    sif.in_amt = '0;
    sif.in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(sif.out_valid), 64'd0);
    chk("rst_out_data", 64'(sif.out_data), 64'd0);
    chk("rst_out_tag", 64'(sif.out_tag), 64'd0);
    chk("rst_in_ready", 64'(sif.in_ready), 64'd1);
`ifdef SHIFTER_CARRY_EN
    chk("rst_out_carry", 64'(sif.out_carry), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: SRA sign fill, AMT_W cycles counting the acceptance edge
    send_exp(32'h8000_0000, 2'b01, 4, 4'd3, 32'hF800_0000, 1'b0);
    idle();
    lat = 1;
    while (!sif.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(AW));
    wait_drain();

    // Rotate then SRL back to back; results on consecutive cycles
    send_exp(32'h0000_0001, 2'b11, 1, 4'd5, 32'h8000_0000, 1'b1);
    send_exp(32'hF000_0000, 2'b00, 28, 4'd6, 32'h0000_000F, 1'b0);
    idle();
    wait_drain();
    chk("b2b_gap", 64'(last_pop_cyc - prev_pop_cyc), 64'd1);

    // Stall: fill all stages with SLL of 1, then hold the output
    rdy_mode = 2;
    @(posedge clk);
    #1;
    for (int s = 0; s < AW; s++) send_exp(32'h1, 2'b10, s, 4'(s), 32'h1 << s, 1'b0);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(sif.in_ready), 64'd0);
      chk("stall_out_valid", 64'(sif.out_valid), 64'd1);
      chk("stall_out_data", 64'(sif.out_data), 64'h1);
      @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    wait_drain();

    // Reset with three operations in flight
    send(32'h1234_5678, 2'b00, 3, 4'd1);
    send(32'h8765_4321, 2'b10, 7, 4'd2);
    send(32'hDEAD_BEEF, 2'b11, 9, 4'd3);
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(sif.out_valid), 64'd0);
    chk("midrst_out_data", 64'(sif.out_data), 64'd0);
    chk("midrst_in_ready", 64'(sif.in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sif.out_valid) quiet++;
    end
    chk("post_rst_outputs", 64'(quiet), 64'd0);
    @(posedge clk);
    #1;

    // Carry cases
    send_exp(32'h0000_0003, 2'b00, 1, 4'd7, 32'h0000_0001, 1'b1);
    send_exp(32'h8000_0000, 2'b10, 1, 4'd8, 32'h0000_0000, 1'b1);
    send_exp(32'h0000_0005, 2'b00, 0, 4'd9, 32'h0000_0005, 1'b0);
    idle();
    wait_drain();

    // Sweep all ops and amounts with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 256; i += 4) begin
      for (int op = 0; op < 4; op++) begin
        for (int s = 0; s < AW; s++) begin
          logic [W-1:0] d;
          d = W'(i);
          if (((i >> 2) & 1) == 1) d = d | ({$urandom()} << 8);
          send(d, 2'(op), s, 4'(i + s));
        end
      end
    end
    idle();
    rdy_mode = 0;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=%0d expected=0", cyc);
    $fatal(1, "timeout");
  end
endmodule
